// File: rtl/vend_multi_if.sv
// Coin-side and dispenser-side signals of the vending controller.
// The controller uses the slave modport; the coin acceptor/test side uses the master modport.
interface vend_multi_if #(
   parameter int CREDIT_W = 8,
   parameter int CNT_W    = 16
) ();
   logic [1:0]          in;
   logic                cancel;
   logic                out;
   logic [1:0]          change;
   logic                coin_rej;
   logic                busy;
   logic [CREDIT_W-1:0] credit;
   logic [CNT_W-1:0]    sales_cnt;

   modport master (
      output in, cancel,
      input  out, change, coin_rej, busy, credit, sales_cnt
   );

   modport slave (
      input  in, cancel,
      output out, change, coin_rej, busy, credit, sales_cnt
   );
endinterface

// File: rtl/vend_multi.sv
// Vending controller with programmable price, 20tk/10tk change payout, cancel/refund,
// coin rejection while busy and a wrapping sales counter. All outputs are registered.
module vend_multi #(
   parameter int CREDIT_W  = 8,
   parameter int PRICE     = 6,
   parameter int COIN1_VAL = 1,
   parameter int COIN2_VAL = 5,
   parameter int COIN3_VAL = 6,
   parameter int CHG20_EN  = 1,
   parameter int CNT_W     = 16
) (
   input logic          clk,
   input logic          res,
   vend_multi_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } state_t;

   localparam logic [CREDIT_W:0]   MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [CREDIT_W:0]   PRICE_X    = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W-1:0] PRICE_W    = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   C1         = (CREDIT_W+1)'(COIN1_VAL);
   localparam logic [CREDIT_W:0]   C2         = (CREDIT_W+1)'(COIN2_VAL);
   localparam logic [CREDIT_W:0]   C3         = (CREDIT_W+1)'(COIN3_VAL);

   state_t              r_state, w_state_next;
   logic [CREDIT_W-1:0] r_credit, w_credit_next;
   logic [CNT_W-1:0]    r_sales, w_sales_next;
   logic                r_out, w_out_next;
   logic [1:0]          r_change, w_change_next;
   logic                r_coin_rej, w_rej_next;
   logic                r_busy, w_busy_next;

   logic [CREDIT_W:0]   w_coin_val;
   logic [CREDIT_W:0]   w_nc;
   logic                w_coin;
   logic                w_pay20;
   logic [CREDIT_W-1:0] w_pay_amt;
   logic [1:0]          w_pay_code;

   assign w_coin     = (bus.in != 2'b00);
   assign w_coin_val = (bus.in == 2'b01) ? C1 :
                       (bus.in == 2'b10) ? C2 :
                       (bus.in == 2'b11) ? C3 : '0;
   // One bit of headroom so an overflowing coin can be detected and rejected.
   assign w_nc       = {1'b0, r_credit} + w_coin_val;
   assign w_pay20    = (CHG20_EN != 0) && (r_credit >= CREDIT_W'(2));
   assign w_pay_amt  = w_pay20 ? CREDIT_W'(2) : CREDIT_W'(1);
   assign w_pay_code = w_pay20 ? 2'b10 : 2'b01;

   // Every entry into CHANGE already emits its first pulse, so change is high only in CHANGE.
   always_comb begin
      w_state_next  = r_state;
      w_credit_next = r_credit;
      w_sales_next  = r_sales;
      w_out_next    = 1'b0;
      w_change_next = 2'b00;
      w_rej_next    = 1'b0;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (r_state == S_COLLECT && bus.cancel) begin
               w_state_next  = S_CHANGE;
               w_change_next = w_pay_code;
               w_credit_next = r_credit - w_pay_amt;
               w_rej_next    = w_coin;
            end else if (w_coin) begin
               if (w_nc > MAX_CREDIT) begin
                  w_rej_next = 1'b1;
               end else if (w_nc >= PRICE_X) begin
                  w_state_next  = S_VEND;
                  w_credit_next = w_nc[CREDIT_W-1:0] - PRICE_W;
                  w_out_next    = 1'b1;
                  w_sales_next  = r_sales + CNT_W'(1);
               end else begin
                  w_state_next  = S_COLLECT;
                  w_credit_next = w_nc[CREDIT_W-1:0];
               end
            end
         end
         S_VEND, S_CHANGE: begin
            w_rej_next = w_coin;
            if (r_credit == '0) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next  = S_CHANGE;
               w_change_next = w_pay_code;
               w_credit_next = r_credit - w_pay_amt;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      w_busy_next = (w_state_next == S_VEND) || (w_state_next == S_CHANGE);
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state    <= S_IDLE;
         r_credit   <= '0;
         r_sales    <= '0;
         r_out      <= 1'b0;
         r_change   <= 2'b00;
         r_coin_rej <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_credit   <= w_credit_next;
         r_sales    <= w_sales_next;
         r_out      <= w_out_next;
         r_change   <= w_change_next;
         r_coin_rej <= w_rej_next;
         r_busy     <= w_busy_next;
      end
   end

   assign bus.out       = r_out;
   assign bus.change    = r_change;
   assign bus.coin_rej  = r_coin_rej;
   assign bus.busy      = r_busy;
   assign bus.credit    = r_credit;
   assign bus.sales_cnt = r_sales;
endmodule
